// File: rtl/jpeg_enc_pkg.sv
// Shared constants for the JPEG encoder front end: BT.601 full-range RGB->YCbCr
// coefficients (Q2.14), rounding/level-shift constants and datapath widths.
package jpeg_enc_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned COMP_W_DEF = 12;
  localparam int unsigned COEF_W     = 16;
  localparam int unsigned COEF_FRAC  = 14;
  localparam int unsigned PROD_W     = 25;
  localparam int unsigned ACC_W      = 26;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam coef_t C_Y_R  =  16'sd4899;
  localparam coef_t C_Y_G  =  16'sd9617;
  localparam coef_t C_Y_B  =  16'sd1868;

  localparam coef_t C_CB_R = -16'sd2765;
  localparam coef_t C_CB_G = -16'sd5427;
  localparam coef_t C_CB_B =  16'sd8192;

  localparam coef_t C_CR_R =  16'sd8192;
  localparam coef_t C_CR_G = -16'sd6860;
  localparam coef_t C_CR_B = -16'sd1332;

  localparam acc_t ROUND_HALF  = 26'sd8192;
  localparam acc_t LEVEL_SHIFT = 26'sd128;
  localparam acc_t SAT_MAX     = 26'sd127;
  localparam acc_t SAT_MIN     = -26'sd128;

  function automatic acc_t sat8(input acc_t v);
    if (v > SAT_MAX)
      return SAT_MAX;
    else if (v < SAT_MIN)
      return SAT_MIN;
    else
      return v;
  endfunction

endpackage

// File: rtl/ycc_dot3.sv
// Registered 3-term multiply-accumulate with round-half-up, offset and optional
// saturation to [-128,127] when RGB2YCC_CLAMP_EN is defined. Two register stages.
module ycc_dot3
  import jpeg_enc_pkg::*;
#(
  parameter coef_t       C_R    = '0,
  parameter coef_t       C_G    = '0,
  parameter coef_t       C_B    = '0,
  parameter acc_t        OFFSET = '0,
  parameter int unsigned OUT_W  = COMP_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_ld1,
  input  logic                    i_ld2,
  input  logic [PIX_W-1:0]        i_r,
  input  logic [PIX_W-1:0]        i_g,
  input  logic [PIX_W-1:0]        i_b,
  output logic signed [OUT_W-1:0] o_comp
);

  logic signed [PROD_W-1:0] w_pr, w_pg, w_pb;
  logic signed [PROD_W-1:0] r_pr, r_pg, r_pb;
  acc_t                     w_acc, w_rnd, w_lvl, w_fin;
  logic signed [OUT_W-1:0]  r_comp;

  // Pixels are unsigned: zero-extend to a signed operand before multiplying.
  assign w_pr = PROD_W'(C_R) * PROD_W'($signed({1'b0, i_r}));
  assign w_pg = PROD_W'(C_G) * PROD_W'($signed({1'b0, i_g}));
  assign w_pb = PROD_W'(C_B) * PROD_W'($signed({1'b0, i_b}));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pr <= '0;
      r_pg <= '0;
      r_pb <= '0;
    end else if (i_ld1) begin
      r_pr <= w_pr;
      r_pg <= w_pg;
      r_pb <= w_pb;
    end
  end

  assign w_acc = ACC_W'(r_pr) + ACC_W'(r_pg) + ACC_W'(r_pb) + ROUND_HALF;
  assign w_rnd = w_acc >>> COEF_FRAC;
  assign w_lvl = w_rnd - OFFSET;

`ifdef RGB2YCC_CLAMP_EN
  assign w_fin = sat8(w_lvl);
`else
  assign w_fin = w_lvl;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      r_comp <= '0;
    else if (i_ld2)
      r_comp <= OUT_W'(w_fin);
  end

  assign o_comp = r_comp;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// RGB -> level-shifted signed {Y,Cb,Cr}, latency 2, one pixel per clock.
// Optional saturation of each component enabled by RGB2YCC_CLAMP_EN.
module rgb_to_ycbcr
  import jpeg_enc_pkg::*;
#(
  parameter int unsigned OUT_W = COMP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   r,
  input  logic [PIX_W-1:0]   g,
  input  logic [PIX_W-1:0]   b,
  output logic               out_valid,
  output logic [3*OUT_W-1:0] out
);

  logic                    r_v1, r_v2;
  logic signed [OUT_W-1:0] w_y, w_cb, w_cr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
    end
  end

  ycc_dot3 #(
    .C_R(C_Y_R), .C_G(C_Y_G), .C_B(C_Y_B), .OFFSET(LEVEL_SHIFT), .OUT_W(OUT_W)
  ) u_y (
    .clk(clk), .reset(reset), .i_ld1(in_valid), .i_ld2(r_v1),
    .i_r(r), .i_g(g), .i_b(b), .o_comp(w_y)
  );

  ycc_dot3 #(
    .C_R(C_CB_R), .C_G(C_CB_G), .C_B(C_CB_B), .OFFSET('0), .OUT_W(OUT_W)
  ) u_cb (
    .clk(clk), .reset(reset), .i_ld1(in_valid), .i_ld2(r_v1),
    .i_r(r), .i_g(g), .i_b(b), .o_comp(w_cb)
  );

  ycc_dot3 #(
    .C_R(C_CR_R), .C_G(C_CR_G), .C_B(C_CR_B), .OFFSET('0), .OUT_W(OUT_W)
  ) u_cr (
    .clk(clk), .reset(reset), .i_ld1(in_valid), .i_ld2(r_v1),
    .i_r(r), .i_g(g), .i_b(b), .o_comp(w_cr)
  );

  assign out_valid = r_v2;
  assign out       = {w_y, w_cb, w_cr};

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Directed + random-stream bench for rgb_to_ycbcr (default OUT_W=12).
module tb_rgb_to_ycbcr;

  localparam int OUT_W = 12;
  localparam int NCYC  = 70;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic [7:0]         r, g, b;
  logic               out_valid;
  logic [3*OUT_W-1:0] out;

  logic signed [OUT_W-1:0] oy, ocb, ocr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sr [NCYC];
  logic [7:0] sg [NCYC];
  logic [7:0] sb [NCYC];
  logic       sv [NCYC];

  rgb_to_ycbcr #(.OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .r(r), .g(g), .b(b),
    .out_valid(out_valid), .out(out)
  );

  assign oy  = out[3*OUT_W-1 -: OUT_W];
  assign ocb = out[2*OUT_W-1 -: OUT_W];
  assign ocr = out[OUT_W-1 -: OUT_W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int cr, input int cg, input int cb,
                               input int pr, input int pg, input int pb,
                               input int ofs);
    int acc, v;
    acc = cr * pr + cg * pg + cb * pb;
    v = ((acc + 8192) >>> 14) - ofs;
`ifdef RGB2YCC_CLAMP_EN
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`endif
    return v;
  endfunction

  task automatic apply_px(input string tag, input int pr, input int pg, input int pb,
                          input int ey, input int ecb, input int ecr);
    in_valid = 1'b1;
    r = 8'(pr); g = 8'(pg); b = 8'(pb);
    tick();
    in_valid = 1'b0;
    check({tag, "_v_lat1"}, 64'(out_valid), 0);
    tick();
    check({tag, "_v"},  64'(out_valid), 1);
    check({tag, "_y"},  64'(oy),  64'(ey));
    check({tag, "_cb"}, 64'(ocb), 64'(ecb));
    check({tag, "_cr"}, 64'(ocr), 64'(ecr));
    tick();
  endtask

  initial begin
    int hy, hcb, hcr;
    int cr_red, cb_blue;
`ifdef RGB2YCC_CLAMP_EN
    cr_red = 127; cb_blue = 127;
`else
    cr_red = 128; cb_blue = 128;
`endif

    reset = 1'b1; in_valid = 1'b0; r = '0; g = '0; b = '0;
    repeat (3) tick();
    check("rst_v",   64'(out_valid), 0);
    check("rst_out", $signed({28'd0, out}), 0);
    reset = 1'b0;
    tick();

    apply_px("black", 0,   0,   0,   -128, 0, 0);
    apply_px("white", 255, 255, 255,  127, 0, 0);
    apply_px("gray",  128, 128, 128,    0, 0, 0);
    apply_px("red",   255, 0,   0,    -52, -43, cr_red);
    apply_px("blue",  0,   0,   255,  -99, cb_blue, -21);

    // idle cycle: out_valid low, data held from the last valid pixel
    check("hold_v",  64'(out_valid), 0);
    check("hold_y",  64'(oy),  -99);
    check("hold_cb", 64'(ocb), 64'(cb_blue));

    hy = -99; hcb = cb_blue; hcr = -21;
    for (int i = 0; i < NCYC; i++) begin
      sr[i] = 8'($urandom_range(0, 255));
      sg[i] = 8'($urandom_range(0, 255));
      sb[i] = 8'($urandom_range(0, 255));
      sv[i] = !(i >= 30 && i < 36);
    end

    for (int i = 0; i <= NCYC; i++) begin
      if (i < NCYC) begin
        in_valid = sv[i]; r = sr[i]; g = sg[i]; b = sb[i];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        int j;
        j = i - 1;
        if (sv[j]) begin
          hy  = model(4899, 9617, 1868, int'(sr[j]), int'(sg[j]), int'(sb[j]), 128);
          hcb = model(-2765, -5427, 8192, int'(sr[j]), int'(sg[j]), int'(sb[j]), 0);
          hcr = model(8192, -6860, -1332, int'(sr[j]), int'(sg[j]), int'(sb[j]), 0);
        end
        check($sformatf("rnd%0d_v", j),  64'(out_valid), 64'(sv[j]));
        check($sformatf("rnd%0d_y", j),  64'(oy),  64'(hy));
        check($sformatf("rnd%0d_cb", j), 64'(ocb), 64'(hcb));
        check($sformatf("rnd%0d_cr", j), 64'(ocr), 64'(hcr));
      end
    end

    // two pixels in flight when reset arrives
    in_valid = 1'b1; r = 8'd255; g = 8'd0; b = 8'd0;
    tick();
    in_valid = 1'b1; r = 8'd0; g = 8'd0; b = 8'd255; reset = 1'b1;
    tick();
    check("mrst_v",   64'(out_valid), 0);
    check("mrst_out", $signed({28'd0, out}), 0);
    reset = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst%0d_v", k),   64'(out_valid), 0);
      check($sformatf("post_rst%0d_out", k), $signed({28'd0, out}), 0);
    end
    apply_px("after_rst", 255, 255, 255, 127, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
